// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets a CPU port and a debug/loader
// port share one byte-wide data memory. Each granted request moves one
// big-endian word as four consecutive byte beats, then pulses that port's ack.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack            last completed CPU read word, completion pulse
//   dbg_*                         same set for the debug/loader port
//   mem_addr/wdata/we, mem_rdata  byte-wide memory; read data is combinational
//   busy                          high while a transaction is in XFER or DONE
//   grant                         current or last owner (0 = CPU, 1 = debug)
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              grant
);

    localparam int unsigned NBEATS = DATA_W / 8;
    localparam int unsigned BEAT_W = $clog2(NBEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic                pick_dbg;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            grant_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
        end
    end

    // Next-state, arbitration and beat sequencing.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        pick_dbg    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On contention the port not granted last time wins.
                    pick_dbg = dbg_req && (!cpu_req || !grant_q);
                    grant_d  = pick_dbg;
                    we_d     = pick_dbg ? dbg_we    : cpu_we;
                    addr_d   = pick_dbg ? dbg_addr  : cpu_addr;
                    data_d   = pick_dbg ? dbg_wdata : cpu_wdata;
                    beat_d   = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                // One register serves both directions: write bytes leave from
                // the top while read bytes enter at the bottom.
                data_d = {data_q[DATA_W-9:0], mem_rdata};
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    beat_d  = '0;
                    if (!we_q) begin
                        if (grant_q) begin
                            dbg_rdata_d = data_d;
                        end else begin
                            cpu_rdata_d = data_d;
                        end
                    end
                    cpu_ack_d = !grant_q;
                    dbg_ack_d = grant_q;
                end else begin
                    beat_d = BEAT_W'(beat_q + 1'b1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory bus is quiet outside XFER; reset also blocks the in-flight byte.
    assign mem_addr  = (state_q == XFER) ? ADDR_W'(addr_q + ADDR_W'(beat_q)) : '0;
    assign mem_we    = (state_q == XFER) && we_q && !reset;
    assign mem_wdata = ((state_q == XFER) && we_q) ? data_q[DATA_W-1 -: 8] : 8'h00;

    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 6, byte address width (64-byte data memory).
- DATA_W, 32, requester word width (4 bytes, big-endian).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high reset.
- cpu_req, in, 1, CPU access request; held until cpu_ack.
- cpu_we, in, 1, 1 = word write, 0 = word read.
- cpu_addr, in, ADDR_W, byte address of MSB byte.
- cpu_wdata, in, DATA_W, write word.
- cpu_rdata, out, DATA_W, last completed CPU read word.
- cpu_ack, out, 1, one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same directions, widths and meanings for the debug/loader port.
- mem_addr, out, ADDR_W, byte address to the byte-wide data memory.
- mem_wdata, out, 8, write byte.
- mem_we, out, 1, byte write strobe.
- mem_rdata, in, 8, byte read data, combinational from mem_addr.
- busy, out, 1, high when state is not IDLE.
- grant, out, 1, current or last owner: 0 = CPU, 1 = debug.

Function
REQ-003 The FSM SHALL have states IDLE, XFER and DONE.
REQ-004 In IDLE, a sampled high request SHALL latch that port's we, addr and wdata, set grant, and move to XFER with beat = 0.
REQ-005 Arbitration SHALL be round-robin: when both requests are high in IDLE, the port not granted last wins; a single requester always wins.
REQ-006 XFER SHALL last exactly 4 cycles, beat 0..3: mem_addr = latched addr + beat, modulo 2^ADDR_W, so address 62 accesses bytes 62, 63, 0, 1.
REQ-007 Byte order SHALL be big-endian: beat 0 carries bits 31:24 and beat 3 carries bits 7:0.
REQ-008 For writes in XFER, mem_we = 1 and mem_wdata = the selected byte of the latched wdata.
REQ-009 For reads in XFER, mem_we = 0 and mem_rdata SHALL be captured into a shift register at the end of each beat.
REQ-010 After beat 3 the FSM SHALL enter DONE for one cycle: the granted port's ack = 1, and for reads its rdata register loads the assembled word, visible in the same DONE cycle.
REQ-011 DONE SHALL always return to IDLE.
REQ-012 Latency SHALL be: request sampled in IDLE at cycle T gives XFER at T+1..T+4, ack at T+5 and IDLE at T+6; minimum spacing between transactions is 6 cycles.
REQ-013 Outside XFER, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-014 Each rdata output SHALL hold its value until that port's next read completes; writes and the other port's reads SHALL NOT change it.
REQ-015 A request deasserted mid-transaction SHALL NOT abort it; the transfer completes and ack is still pulsed.
REQ-016 A request still high in the IDLE cycle after ack SHALL be treated as a new transaction.
REQ-017 Unaligned addresses SHALL be legal, with no alignment check.
REQ-018 busy SHALL be 1 in XFER and DONE, and 0 in IDLE.
REQ-019 The two acks SHALL never be high in the same cycle.

Reset
REQ-020 When reset is high at a rising edge, the block SHALL next be in IDLE with:
- beat = 0 and grant = 1, so the CPU wins the first contention;
- cpu_rdata = dbg_rdata = 0 and shift register = 0;
- both acks = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0 and busy = 0.
REQ-021 Reset during XFER or DONE SHALL abandon the transaction: no ack is issued, and bytes already written remain in memory.
REQ-022 Reset SHALL take priority over every request.

Verification
REQ-023 CPU write: cpu_addr = 4, cpu_wdata = 0xDEADBEEF, cpu_we = 1 -> beats write 0xDE@4, 0xAD@5, 0xBE@6 and 0xEF@7 with mem_we = 1; cpu_ack at T+5.
REQ-024 CPU read of the same location -> cpu_rdata = 0xDEADBEEF in the ack cycle; dbg_rdata stays 0.
REQ-025 Wrap: dbg write to addr 62 with 0x11223344 -> bytes 0x11@62, 0x22@63, 0x33@0, 0x44@1; a dbg read at addr 62 returns 0x11223344.
REQ-026 Contention: both requests high from reset release -> CPU served first (ack at T+5); debug granted in the next IDLE (grant = 1); a third contention goes to the CPU.
REQ-027 Reset mid-write: CPU write of 0xAABBCCDD to addr 8 with reset asserted during beat 2 -> bytes 8 and 9 written, bytes 10 and 11 unchanged; no ack; IDLE and busy = 0 on the next cycle.
REQ-028 Request dropped: cpu_req pulsed for 1 cycle -> full 4-beat transfer and cpu_ack still pulsed once; no second transaction.
